// File: rtl/reaction_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// reaction_round_ctrl_if
// Player-facing bundle of the reaction-game round controller.
//   btn_up, btn_down, btn_sel : debounced button levels (into the controller)
//   rand_num                  : free-running random value (into the controller)
//   state                     : 0 IDLE, 1 TARGET, 2 COUNT, 3 SCORE, 4 SUMMARY
//   mode                      : selected difficulty
//   number                    : value to display
//   led                       : accuracy bar
//   round                     : current round index, from 0
//   total_score, best_score   : session sum of errors / best completed session
//   done                      : high while in SUMMARY
// The random input is called rand_num because "rand" is a SystemVerilog keyword.
// master = stimulus / board side, slave = the controller.
// ---------------------------------------------------------------------------
interface reaction_round_ctrl_if #(
    parameter int NUM_W     = 14,
    parameter int NUM_MODES = 3,
    parameter int LED_N     = 16,
    parameter int ROUNDS    = 3,
    parameter int SCORE_W   = 16
);
    localparam int MODE_W  = $clog2(NUM_MODES);
    localparam int ROUND_W = $clog2(ROUNDS + 1);

    logic               btn_up;
    logic               btn_down;
    logic               btn_sel;
    logic [NUM_W-1:0]   rand_num;
    logic [2:0]         state;
    logic [MODE_W-1:0]  mode;
    logic [NUM_W-1:0]   number;
    logic [LED_N-1:0]   led;
    logic [ROUND_W-1:0] round;
    logic [SCORE_W-1:0] total_score;
    logic [SCORE_W-1:0] best_score;
    logic               done;

    modport master (
        output btn_up, btn_down, btn_sel, rand_num,
        input  state, mode, number, led, round, total_score, best_score, done
    );

    modport slave (
        input  btn_up, btn_down, btn_sel, rand_num,
        output state, mode, number, led, round, total_score, best_score, done
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_round_ctrl
// Multi-round controller for the reaction game, running on the 20 Hz tick.
// Difficulty menu, target latching from the random source, saturating count
// phase, per-round error-to-LED scoring, session total and best score.
// Ports:
//   clk_20Hz : clock, all state changes on its rising edge
//   rst      : asynchronous active-high reset
//   bus      : reaction_round_ctrl_if.slave (buttons, random value, outputs)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module reaction_round_ctrl #(
    parameter int NUM_W        = 14,
    parameter int NUM_MODES    = 3,
    parameter int DEFAULT_MODE = 1,
    parameter int STEP0        = 10,
    parameter int LED_N        = 16,
    parameter int BUCKET       = 30,
    parameter int ROUNDS       = 3,
    parameter int SCORE_W      = 16
) (
    input  logic               clk_20Hz,
    input  logic               rst,
    reaction_round_ctrl_if.slave bus
);
    localparam int MODE_W  = $clog2(NUM_MODES);
    localparam int ROUND_W = $clog2(ROUNDS + 1);

    localparam logic [MODE_W-1:0]  MODE_MAX   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0]  MODE_RST   = MODE_W'(DEFAULT_MODE);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
    localparam logic [NUM_W-1:0]   NUM_MAX    = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LED_N-1:0]   LED_ONES   = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TARGET  = 3'd1,
        S_COUNT   = 3'd2,
        S_SCORE   = 3'd3,
        S_SUMMARY = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [MODE_W-1:0]  mode_q,   mode_d;
    logic [NUM_W-1:0]   number_q, number_d;
    logic [NUM_W-1:0]   target_q, target_d;
    logic [LED_N-1:0]   led_q,    led_d;
    logic [ROUND_W-1:0] round_q,  round_d;
    logic [SCORE_W-1:0] total_q,  total_d;
    logic [SCORE_W-1:0] best_q,   best_d;
    logic               done_q,   done_d;
    logic               btn_up_q, btn_down_q, btn_sel_q;

    logic               up_press, down_press, sel_press;
    logic [31:0]        step;
    logic [31:0]        count_sum;
    logic [NUM_W-1:0]   number_inc;
    logic [NUM_W-1:0]   err;
    logic [31:0]        off;
    logic [LED_N-1:0]   led_score;
    logic [31:0]        total_sum;
    logic [SCORE_W-1:0] total_sat;

    // Datapath helpers, all computed from current state.
    always_comb begin
        up_press   = bus.btn_up   & ~btn_up_q;
        down_press = bus.btn_down & ~btn_down_q;
        sel_press  = bus.btn_sel  & ~btn_sel_q;

        step       = 32'(STEP0) << mode_q;
        count_sum  = 32'(number_q) + step;
        number_inc = (count_sum > 32'(NUM_MAX)) ? NUM_MAX : count_sum[NUM_W-1:0];

        err        = (number_q >= target_q) ? (number_q - target_q) : (target_q - number_q);
        off        = 32'(err) / 32'(BUCKET);
        // Shifting ones left by off clears the low off LEDs, keeping the top lit.
        led_score  = (off >= 32'(LED_N)) ? '0 : (LED_ONES << off);

        total_sum  = 32'(total_q) + 32'(err);
        total_sat  = (total_sum > 32'(SCORE_MAX)) ? SCORE_MAX : total_sum[SCORE_W-1:0];
    end

    // Next-state logic. A sel press takes precedence over up/down everywhere.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        number_d = number_q;
        target_d = target_q;
        led_d    = led_q;
        round_d  = round_q;
        total_d  = total_q;
        best_d   = best_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (sel_press) begin
                    target_d = bus.rand_num;
                    number_d = bus.rand_num;
                    state_d  = S_TARGET;
                end else if (up_press && !down_press) begin
                    if (mode_q != MODE_MAX) mode_d = mode_q + MODE_W'(1);
                end else if (down_press && !up_press) begin
                    if (mode_q != '0) mode_d = mode_q - MODE_W'(1);
                end
            end
            S_TARGET: begin
                if (sel_press) begin
                    number_d = '0;
                    state_d  = S_COUNT;
                end
            end
            S_COUNT: begin
                // The stopping cycle does not count; score uses the held number.
                if (sel_press) begin
                    led_d   = led_score;
                    total_d = total_sat;
                    state_d = S_SCORE;
                end else begin
                    number_d = number_inc;
                end
            end
            S_SCORE: begin
                if (sel_press) begin
                    if (round_q < ROUND_LAST) begin
                        round_d  = round_q + ROUND_W'(1);
                        target_d = bus.rand_num;
                        number_d = bus.rand_num;
                        led_d    = '0;
                        state_d  = S_TARGET;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_SUMMARY;
                        if (total_q < best_q) best_d = total_q;
                    end
                end
            end
            S_SUMMARY: begin
                if (sel_press) begin
                    round_d  = '0;
                    total_d  = '0;
                    led_d    = '0;
                    number_d = '0;
                    done_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Previous button samples reset high so a button held through reset
    // release is not seen as a press.
    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_RST;
            number_q   <= '0;
            target_q   <= '0;
            led_q      <= '0;
            round_q    <= '0;
            total_q    <= '0;
            best_q     <= SCORE_MAX;
            done_q     <= 1'b0;
            btn_up_q   <= 1'b1;
            btn_down_q <= 1'b1;
            btn_sel_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            number_q   <= number_d;
            target_q   <= target_d;
            led_q      <= led_d;
            round_q    <= round_d;
            total_q    <= total_d;
            best_q     <= best_d;
            done_q     <= done_d;
            btn_up_q   <= bus.btn_up;
            btn_down_q <= bus.btn_down;
            btn_sel_q  <= bus.btn_sel;
        end
    end

    assign bus.state       = state_q;
    assign bus.mode        = mode_q;
    assign bus.number      = number_q;
    assign bus.led         = led_q;
    assign bus.round       = round_q;
    assign bus.total_score = total_q;
    assign bus.best_score  = best_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_round_ctrl
// Self-checking bench for reaction_round_ctrl with default parameters.
// Expected values come from a session-level model: mode saturates in [0,2],
// a round's count is min(n * (10 << mode), 16383), error is |count - target|,
// the LED bar has bit i lit when i >= error/30, totals add and saturate.
// ---------------------------------------------------------------------------
module tb_reaction_round_ctrl;
    logic clk;
    logic rst;

    reaction_round_ctrl_if #(
        .NUM_W(14), .NUM_MODES(3), .LED_N(16), .ROUNDS(3), .SCORE_W(16)
    ) bus ();

    reaction_round_ctrl #(
        .NUM_W(14), .NUM_MODES(3), .DEFAULT_MODE(1), .STEP0(10),
        .LED_N(16), .BUCKET(30), .ROUNDS(3), .SCORE_W(16)
    ) dut (
        .clk_20Hz (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Session-level model.
    int m_mode;
    int m_round;
    int m_total;
    int m_best;
    bit m_after_score;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_raw();
        bus.btn_sel = 1'b1;
        tick();
        bus.btn_sel = 1'b0;
    endtask

    task automatic sel();
        sel_raw();
        tick();
    endtask

    task automatic press(input bit up, input bit down, input bit s);
        bus.btn_up   = up;
        bus.btn_down = down;
        bus.btn_sel  = s;
        tick();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] model_led(input int err);
        logic [15:0] v;
        int off;
        off = err / 30;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = (i >= off);
        return v;
    endfunction

    task automatic model_reset();
        m_mode        = 1;
        m_round       = 0;
        m_total       = 0;
        m_best        = 65535;
        m_after_score = 1'b0;
    endtask

    task automatic do_reset();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    // One round from IDLE/SCORE through TARGET, n counting cycles, stop.
    // exp_led >= 0 overrides the model with a literal expected bar.
    task automatic play_round(input int r, input int n, input int exp_led, input string tag);
        int exp_num;
        int err;
        logic [15:0] led_exp;
        if (m_after_score) m_round++;
        bus.rand_num = 14'(r);
        sel();
        n_cmp++;
        if (bus.state !== 3'd1 || bus.number !== 14'(r) || bus.round !== 2'(m_round)) begin
            n_fail++;
            $display("FAIL %s target: state=%0d number=%0d round=%0d, required state=1 number=%0d round=%0d",
                     tag, bus.state, bus.number, bus.round, r, m_round);
        end
        bus.rand_num = 14'($urandom_range(0, 16383));
        sel_raw();
        n_cmp++;
        if (bus.state !== 3'd2 || bus.number !== 14'd0) begin
            n_fail++;
            $display("FAIL %s count_start: state=%0d number=%0d, required state=2 number=0",
                     tag, bus.state, bus.number);
        end
        repeat (n) tick();
        exp_num = n * (10 << m_mode);
        if (exp_num > 16383) exp_num = 16383;
        n_cmp++;
        if (bus.number !== 14'(exp_num)) begin
            n_fail++;
            $display("FAIL %s count: number=%0d, required %0d", tag, bus.number, exp_num);
        end
        sel_raw();
        tick();
        err = (exp_num >= r) ? exp_num - r : r - exp_num;
        m_total = m_total + err;
        if (m_total > 65535) m_total = 65535;
        led_exp = (exp_led >= 0) ? 16'(exp_led) : model_led(err);
        n_cmp++;
        if (bus.state !== 3'd3 || bus.number !== 14'(exp_num) || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s score_state: state=%0d number=%0d done=%0d, required state=3 number=%0d done=0",
                     tag, bus.state, bus.number, bus.done, exp_num);
        end
        n_cmp++;
        if (bus.led !== led_exp) begin
            n_fail++;
            $display("FAIL %s led: got %h, required %h (err %0d)", tag, bus.led, led_exp, err);
        end
        n_cmp++;
        if (bus.total_score !== 16'(m_total)) begin
            n_fail++;
            $display("FAIL %s total: got %0d, required %0d", tag, bus.total_score, m_total);
        end
        m_after_score = 1'b1;
        $display("round %0d [%s] mode=%0d target=%0d cycles=%0d number=%0d err=%0d led=%h total=%0d",
                 m_round, tag, m_mode, r, n, bus.number, err, bus.led, bus.total_score);
    endtask

    task automatic end_session(input string tag);
        sel();
        if (m_total < m_best) m_best = m_total;
        n_cmp++;
        if (bus.state !== 3'd4 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s summary: state=%0d done=%0d, required state=4 done=1", tag, bus.state, bus.done);
        end
        n_cmp++;
        if (bus.best_score !== 16'(m_best) || bus.total_score !== 16'(m_total)) begin
            n_fail++;
            $display("FAIL %s best: best=%0d total=%0d, required best=%0d total=%0d",
                     tag, bus.best_score, bus.total_score, m_best, m_total);
        end
        sel();
        n_cmp++;
        if (bus.state !== 3'd0 || bus.round !== 2'd0 || bus.total_score !== 16'd0 ||
            bus.number !== 14'd0 || bus.led !== 16'd0 || bus.done !== 1'b0 || bus.mode !== 2'(m_mode)) begin
            n_fail++;
            $display("FAIL %s back_to_idle: state=%0d round=%0d total=%0d number=%0d led=%h done=%0d mode=%0d, required 0/0/0/0/0000/0/%0d",
                     tag, bus.state, bus.round, bus.total_score, bus.number, bus.led, bus.done, bus.mode, m_mode);
        end
        $display("session [%s] total=%0d best=%0d", tag, m_total, bus.best_score);
        m_round       = 0;
        m_total       = 0;
        m_after_score = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b1;
        bus.rand_num = 14'd123;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        model_reset();
        n_cmp++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required 0", bus.state);
        end
        n_cmp++;
        if (bus.mode !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mode: got %0d, required 1", bus.mode);
        end
        n_cmp++;
        if (bus.best_score !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_best: got %h, required ffff", bus.best_score);
        end
        n_cmp++;
        if (bus.number !== 14'd0 || bus.led !== 16'd0 || bus.round !== 2'd0 ||
            bus.total_score !== 16'd0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: number=%0d led=%h round=%0d total=%0d done=%0d, required all zero",
                     bus.number, bus.led, bus.round, bus.total_score, bus.done);
        end
        bus.btn_sel = 1'b0;
        tick();
        $display("reset: state=%0d mode=%0d best=%h", bus.state, bus.mode, bus.best_score);
    endtask

    task automatic test_mode_menu();
        int exp_up[3]   = '{2, 2, 2};
        int exp_down[4] = '{1, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (bus.mode !== 2'(exp_up[i])) begin
                n_fail++;
                $display("FAIL mode_up%0d: got %0d, required %0d", i, bus.mode, exp_up[i]);
            end
            $display("menu up: mode=%0d", bus.mode);
        end
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (bus.mode !== 2'(exp_down[i])) begin
                n_fail++;
                $display("FAIL mode_down%0d: got %0d, required %0d", i, bus.mode, exp_down[i]);
            end
            $display("menu down: mode=%0d", bus.mode);
        end
        press(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.mode !== 2'd0 || bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL mode_updown: mode=%0d state=%0d, required mode=0 state=0", bus.mode, bus.state);
        end
        $display("menu up+down: mode=%0d", bus.mode);
        bus.rand_num = 14'd77;
        press(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.mode !== 2'd0 || bus.state !== 3'd1 || bus.number !== 14'd77) begin
            n_fail++;
            $display("FAIL mode_up_sel: mode=%0d state=%0d number=%0d, required mode=0 state=1 number=77",
                     bus.mode, bus.state, bus.number);
        end
        $display("menu up+sel: state=%0d mode=%0d", bus.state, bus.mode);
        // TARGET ignores up/down.
        press(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.mode !== 2'd0 || bus.state !== 3'd1) begin
            n_fail++;
            $display("FAIL mode_target_locked: mode=%0d state=%0d, required mode=0 state=1", bus.mode, bus.state);
        end
        do_reset();
    endtask

    task automatic test_scoring();
        play_round(100, 5, 16'hFFFF, "exact");
        play_round(500, 10, 16'hFC00, "err300");
        play_round(499, 1, 16'h8000, "err479");
        end_session("scoring");
    endtask

    task automatic test_led_floor();
        play_round(500, 1, 16'h0000, "err480");
        play_round(200, 10, 16'hFFFF, "err0");
        play_round(1000, 5, 16'h0000, "err900");
        end_session("led_floor");
    endtask

    task automatic test_saturation();
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        m_mode = 2;
        play_round(16383, 500, -1, "sat");
        play_round(16383, 450, -1, "sat2");
        play_round(0, 1, -1, "zero_target");
        end_session("saturation");
    endtask

    task automatic test_sessions();
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        m_mode = 0;
        play_round(30, 2, -1, "e10");
        play_round(40, 2, -1, "e20");
        play_round(0, 3, -1, "e30");
        end_session("first60");
        n_cmp++;
        if (bus.best_score !== 16'd60) begin
            n_fail++;
            $display("FAIL best_first: got %0d, required 60", bus.best_score);
        end
        play_round(60, 3, -1, "s2a");
        play_round(60, 3, -1, "s2b");
        play_round(60, 3, -1, "s2c");
        end_session("second90");
        n_cmp++;
        if (bus.best_score !== 16'd60) begin
            n_fail++;
            $display("FAIL best_kept: got %0d, required 60", bus.best_score);
        end
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        play_round(100, 3, -1, "pre_reset");
        bus.rand_num = 14'd900;
        sel();
        sel_raw();
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== 3'd0 || bus.mode !== 2'd1 || bus.number !== 14'd0 || bus.led !== 16'd0 ||
            bus.round !== 2'd0 || bus.total_score !== 16'd0 || bus.best_score !== 16'hFFFF || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: state=%0d mode=%0d number=%0d led=%h round=%0d total=%0d best=%h done=%0d, required 0/1/0/0000/0/0/ffff/0",
                     bus.state, bus.mode, bus.number, bus.led, bus.round, bus.total_score, bus.best_score, bus.done);
        end
        bus.btn_sel = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.state !== 3'd0 || bus.number !== 14'd0 || bus.best_score !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_mid_release: state=%0d number=%0d best=%h, required 0/0/ffff",
                     bus.state, bus.number, bus.best_score);
        end
        $display("mid-round reset: state=%0d best=%h", bus.state, bus.best_score);
        bus.btn_sel = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6; k++) begin
                int kind;
                kind = $urandom_range(0, 2);
                case (kind)
                    0: begin press(1'b1, 1'b0, 1'b0); if (m_mode < 2) m_mode++; end
                    1: begin press(1'b0, 1'b1, 1'b0); if (m_mode > 0) m_mode--; end
                    default: press(1'b1, 1'b1, 1'b0);
                endcase
                n_cmp++;
                if (bus.mode !== 2'(m_mode)) begin
                    n_fail++;
                    $display("FAIL rand_mode: got %0d, required %0d (kind %0d)", bus.mode, m_mode, kind);
                end
            end
            for (int r = 0; r < 3; r++) begin
                int tgt;
                int n;
                tgt = $urandom_range(0, 2000);
                n   = $urandom_range(1, 60);
                play_round(tgt, n, -1, "random");
            end
            end_session("random");
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b0;
        bus.rand_num = '0;
        model_reset();
        test_reset();
        test_mode_menu();
        test_scoring();
        test_led_floor();
        test_saturation();
        test_sessions();
        test_reset_mid_round();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Parametrised round controller for the FPGA reaction game, clocked on the 20 Hz tick domain. Handles the difficulty menu, target latching from the random source, the counting phase, and the per-round error-to-LED scoring. It adds what the single-shot controller lacked:
- configurable mode count, width and LED count;
- multi-round sessions with accumulated and best scores;
- edge-detected buttons with defined priorities;
- a saturating counter.

## Interface
Parameters:
- NUM_W, 14: width of target, count and per-round error.
- NUM_MODES, 3: number of difficulty modes (≥2).
- DEFAULT_MODE, 1: mode after reset.
- STEP0, 10: count increment per tick in mode 0; mode m steps by STEP0 << m.
- LED_N, 16: LED bar width.
- BUCKET, 30: error units per LED turned off.
- ROUNDS, 3: rounds per session (≥1).
- SCORE_W, 16: width of total/best score.

Ports:
- clk_20Hz  in  1  block clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_up, btn_down, btn_sel  in  1 each  synchronised, debounced button levels.
- rand  in  NUM_W  free-running random value.
- state  out  3  0 IDLE, 1 TARGET, 2 COUNT, 3 SCORE, 4 SUMMARY.
- mode  out  $clog2(NUM_MODES)  selected difficulty.
- number  out  NUM_W  value to display.
- led  out  LED_N  accuracy bar.
- round  out  $clog2(ROUNDS+1)  current round index, from 0.
- total_score  out  SCORE_W  sum of round errors this session.
- best_score  out  SCORE_W  lowest completed-session total since reset.
- done  out  1  high in SUMMARY.

## Operation
- Press detection:
  - Each button has a registered previous sample btn_q.
  - press = btn & ~btn_q.
  - A held button yields exactly one press.
- Priority: sel press beats up/down in the same cycle. Up and down pressed together do nothing.
- IDLE:
  - up press increments mode, saturating at NUM_MODES-1.
  - down press decrements mode, saturating at 0.
  - sel press: target ← rand, number ← rand, go to TARGET.
- TARGET: up/down are ignored. sel press: number ← 0, go to COUNT.
- COUNT:
  - Each cycle without a sel press: number ← min(number + (STEP0 << mode), 2^NUM_W-1).
  - sel press: the increment is suppressed that cycle and the block goes to SCORE.
- Entering SCORE (same edge):
  - err = |number - target|, NUM_W bits.
  - off = err / BUCKET.
  - led = (off ≥ LED_N) ? 0 : ~((1<<off)-1), so the upper LED_N-off bits are lit.
  - total_score ← total_score + err, saturating at 2^SCORE_W-1.
- SCORE, on sel press:
  - If round < ROUNDS-1: round+1, target ← rand, number ← rand, led ← 0, go to TARGET.
  - Otherwise: go to SUMMARY, done ← 1, best_score ← min(best_score, total_score).
- SUMMARY, on sel press: round ← 0, total_score ← 0, led ← 0, number ← 0, done ← 0, go to IDLE. mode is retained.
- mode changes only in IDLE.
- A rand of 0 is accepted as a valid target.

## Timing
- All outputs are registered. An action triggered by a press detected at edge k is visible after edge k (zero-cycle latency relative to the sampled press).
- Counting rate is one step per clk_20Hz edge: 20 steps/s.
- Reset values:
  - state IDLE, mode DEFAULT_MODE, number 0, led 0, round 0;
  - total_score 0, best_score all-ones, done 0, target 0;
  - all btn_q 1, so a button held through reset release is not a press.
- Reset mid-round discards the session with no best_score update. Reset asserted during an edge wins over any press.
- Saturation: number and total_score never wrap.
- led is stable from SCORE entry until it is cleared by the next sel.

## Test plan
- Reset with btn_sel held, release rst, keep btn_sel high for 5 cycles -> state stays IDLE, mode=1, best_score=16'hFFFF.
- In IDLE: up ×3 -> mode=2. down ×4 -> mode=0. up+down in the same cycle -> mode unchanged. up+sel in the same cycle -> TARGET, mode unchanged.
- Mode 1, rand=100, sel, sel, 5 COUNT cycles, sel -> number=100, err 0, led=16'hFFFF, total_score=100-100 → 0.
- Mode 1, rand=500, count to number=200 (10 cycles), sel -> led=16'hFC00, total_score+=300. Error 479 -> led=16'h8000. Error 480 -> led=16'h0000.
- NUM_W=14, mode 2, rand=16383, count 500 cycles -> number holds 16383 with no wrap. Full 3-round session with errors 10/20/30 -> done=1, total_score=60, best_score=60. Second session totalling 90 -> best_score stays 60.
- rst asserted mid-COUNT in round 1 -> all outputs at reset values. best_score returns to 16'hFFFF, since reset clears it.
